read_arbiter: RTL and testbench
===============================

# read_arbiter

Output-side read arbiter for the shared-SRAM packet buffer. When the egress port signals `ready`, it picks one of `num_of_priorities` queues under strict-priority or weighted-round-robin policy. It then walks that queue's address stream, issuing one SRAM read per cycle. The returned words are delivered as a framed packet (`rd_sop`/`rd_vld`/`rd_eop`) to the egress port.

## Interface
- `num_of_priorities`, 8: number of priority queues.
- `num_of_ports`, 16: system port count; informational only, unused by logic.
- `address_width`, 12: SRAM address width.
- `arbiter_data_width`, 64: data word width.
- `wrr_weight_width`, 5: WRR weight width.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `sp0_wrr1`  in  1  policy: 0 = strict priority, served on channel 1; 1 = WRR, served on channel 2.
- `ready`  in  1  egress port can accept one packet.
- `prepared`  in  `num_of_priorities`  per queue: a complete packet is available.
- `wrr_weight`  in  `wrr_weight_width`  packets per WRR turn.
- `rd_data`  out  `arbiter_data_width`  packet word to egress.
- `rd_sop` / `rd_vld` / `rd_eop`  out  1 each  start-of-packet / word-valid / end-of-packet.
- `next_data`, `next_data2`  out  `num_of_priorities`  one-hot pop of the channel-1 / channel-2 address stream of the granted queue.
- `data_read`  in  `arbiter_data_width`  SRAM read data.
- `last1`, `last2`  in  1  the current channel-1 / channel-2 address is the packet's final one.
- `address_to_read1`, `address_to_read2`  in  `address_width`  current address offered by the queue.
- `address_read1`, `address_read2`  out  `address_width`  SRAM read address.
- `rd_request1`, `rd_request2`  out  1  channel read in progress.
- `enb`  out  1  SRAM read enable.

## Operation
- States: IDLE, READ, DRAIN.
- IDLE:
  - On `ready`=1 and `prepared`≠0, latch the granted index `sel` and the active channel (from `sp0_wrr1`), then go to READ.
  - `ready` with `prepared`=0 does nothing.
- Strict priority: the highest set index of `prepared` wins; bit 7 beats bit 0.
- WRR:
  - A round-robin pointer resets to 0 and uses a credit counter.
  - If `prepared[ptr]` is set and credit remains, grant `ptr` and consume one credit.
  - Otherwise advance to the next set index upward with wrap, grant it, and reload credit to `wrr_weight`−1.
  - `wrr_weight`=0 is treated as 1. The weight is sampled at reload.
- READ, every cycle on the active channel:
  - `enb`=1, `rd_requestN`=1.
  - `address_readN` = `address_to_readN` (combinational).
  - `next_dataN[sel]`=1.
  - If `lastN`=1, go to DRAIN.
- The inactive channel's outputs stay 0.
- DRAIN: wait 2 cycles for the pipeline to empty, then return to IDLE.
- `ready` is ignored outside IDLE.
- A `prepared` change mid-packet does not abort the packet.

## Timing
- Reset: every output is 0. State = IDLE, WRR pointer = 0, credit = 0.
- Grant sampled at cycle T. Addresses are consumed in cycles T+1..T+L, where L is the cycle in which `last` is high.
- SRAM latency is one cycle: `data_read` is valid in the cycle after the corresponding `enb`.
- `rd_data`/`rd_vld` are registered: word k (address at cycle T+k) appears at T+k+2.
- `rd_sop` accompanies the first word and `rd_eop` the last. For a one-word packet, both are asserted together.
- The earliest new grant is T+L+3, after `rd_eop` has been driven.
- Async reset mid-packet: all outputs drop to 0 immediately and the packet is abandoned.

## Structure
- A shared package holds the parameter defaults and the state encoding.
- Sub-module `read_arbiter_sel` is the combinational SP/WRR selector plus the WRR pointer/credit registers.
- The parent module holds the FSM, the address mux and the output pipeline.

## Test plan
- SP, `prepared`=8'hFF: each `ready` pulse grants 7, so `next_data[7]` pulses and `next_data2`=0.
- WRR, weight 5, `prepared`=8'hFF, 12 packets: grants are 0×5, 1×5, 2×2, seen on `next_data2`.
- Five-address packet (`last2` with the 5th address), `ready` at cycle 0:
  - `enb` high during cycles 1–5.
  - `rd_vld` high during cycles 3–7 with `rd_data` equal to `data_read` of cycles 2–6.
  - `rd_sop` at cycle 3, `rd_eop` at cycle 7.
- `ready` with `prepared`=0, and `ready` asserted during READ: no pops, no `enb`, state unchanged.
- One-address packet: `rd_sop`=`rd_eop`=`rd_vld`=1 in the same cycle.
- `rst` low mid-READ: all outputs 0 at once. After release, the next grant restarts WRR at index 0.

Source files
------------

// File: rtl/read_arbiter_pkg.sv
// Shared definitions for the egress read arbiter: widths, FSM state encoding and
// the priority search helpers used by the selector.
package read_arbiter_pkg;

    localparam int unsigned NumPriorities  = 8;
    localparam int unsigned NumPorts       = 16;  // system port count, informational only
    localparam int unsigned AddrWidth      = 12;
    localparam int unsigned DataWidth      = 64;
    localparam int unsigned WrrWeightWidth = 5;
    localparam int unsigned PrioIdxWidth   = $clog2(NumPriorities);

    typedef logic [PrioIdxWidth-1:0] prio_idx_t;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain
    } state_e;

    // Highest set index wins; returns 0 for an all-zero vector.
    function automatic prio_idx_t highest_set(input logic [NumPriorities-1:0] vec);
        prio_idx_t idx;
        prio_idx_t cand;
        idx = '0;
        for (int unsigned i = 0; i < NumPriorities; i++) begin
            cand = prio_idx_t'(i);
            if (vec[cand]) idx = cand;
        end
        return idx;
    endfunction

    // First set index at or above start, wrapping past the top; start if none set.
    function automatic prio_idx_t next_set_from(input logic [NumPriorities-1:0] vec,
                                                input prio_idx_t start);
        prio_idx_t idx;
        prio_idx_t cand;
        idx = start;
        // Walk offsets downward so the smallest offset is the one left standing.
        for (int unsigned off = NumPriorities; off > 0; off--) begin
            cand = prio_idx_t'((32'(start) + off - 32'd1) % NumPriorities);
            if (vec[cand]) idx = cand;
        end
        return idx;
    endfunction

endpackage

// File: rtl/read_arbiter_if.sv
// Bundle of the queue, SRAM and egress signals seen by the read arbiter.
// master: arbiter side. slave: queue manager / SRAM / egress side.
interface read_arbiter_if;
    import read_arbiter_pkg::*;

    logic                      sp0_wrr1;       // 0 = strict priority (ch1), 1 = WRR (ch2)
    logic                      ready;          // egress can take one packet
    logic [NumPriorities-1:0]  prepared;       // per-queue: full packet available
    logic [WrrWeightWidth-1:0] wrr_weight;     // packets per WRR turn
    logic [DataWidth-1:0]      rd_data;        // packet word to egress
    logic                      rd_sop;
    logic                      rd_vld;
    logic                      rd_eop;
    logic [NumPriorities-1:0]  next_data;      // one-hot pop, channel 1
    logic [NumPriorities-1:0]  next_data2;     // one-hot pop, channel 2
    logic [DataWidth-1:0]      data_read;      // SRAM read data, one cycle after enb
    logic                      last1;
    logic                      last2;
    logic [AddrWidth-1:0]      address_to_read1;
    logic [AddrWidth-1:0]      address_to_read2;
    logic [AddrWidth-1:0]      address_read1;
    logic [AddrWidth-1:0]      address_read2;
    logic                      rd_request1;
    logic                      rd_request2;
    logic                      enb;            // SRAM read enable

    modport master (
        input  sp0_wrr1, ready, prepared, wrr_weight, data_read, last1, last2,
               address_to_read1, address_to_read2,
        output rd_data, rd_sop, rd_vld, rd_eop, next_data, next_data2,
               address_read1, address_read2, rd_request1, rd_request2, enb
    );

    modport slave (
        output sp0_wrr1, ready, prepared, wrr_weight, data_read, last1, last2,
               address_to_read1, address_to_read2,
        input  rd_data, rd_sop, rd_vld, rd_eop, next_data, next_data2,
               address_read1, address_read2, rd_request1, rd_request2, enb
    );

endinterface

// File: rtl/read_arbiter_sel.sv
// Queue selector: combinational strict-priority and weighted-round-robin pick,
// plus the WRR pointer/credit state which only advances on a WRR grant.
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   i_sp0_wrr1      policy select (0 = SP, 1 = WRR)
//   i_grant         arbiter is committing to o_sel this cycle
//   i_prepared      per-queue packet available
//   i_wrr_weight    packets per WRR turn (0 behaves as 1)
//   o_sel           selected queue index
//   o_any           at least one queue prepared
module read_arbiter_sel
    import read_arbiter_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_sp0_wrr1,
    input  logic                      i_grant,
    input  logic [NumPriorities-1:0]  i_prepared,
    input  logic [WrrWeightWidth-1:0] i_wrr_weight,
    output prio_idx_t                 o_sel,
    output logic                      o_any
);

    prio_idx_t                 r_ptr;
    logic [WrrWeightWidth-1:0] r_credit;
    // Set until the first WRR grant so that the search starts at the pointer itself
    // rather than one past it.
    logic                      r_fresh;

    prio_idx_t                 w_sp_sel;
    prio_idx_t                 w_wrr_sel;
    prio_idx_t                 w_start;
    logic                      w_stay;
    logic [WrrWeightWidth-1:0] w_reload;

    always_comb begin
        w_sp_sel  = highest_set(i_prepared);
        w_stay    = !r_fresh && i_prepared[r_ptr] && (r_credit != '0);
        w_start   = r_fresh ? r_ptr : prio_idx_t'((32'(r_ptr) + 32'd1) % NumPriorities);
        w_wrr_sel = w_stay ? r_ptr : next_set_from(i_prepared, w_start);
        w_reload  = (i_wrr_weight == '0) ? '0 : i_wrr_weight - 1'b1;
        o_sel     = i_sp0_wrr1 ? w_wrr_sel : w_sp_sel;
        o_any     = |i_prepared;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr    <= '0;
            r_credit <= '0;
            r_fresh  <= 1'b1;
        end else if (i_grant && i_sp0_wrr1) begin
            r_fresh <= 1'b0;
            if (w_stay) begin
                r_credit <= r_credit - 1'b1;
            end else begin
                r_ptr    <= w_wrr_sel;
                r_credit <= w_reload;
            end
        end
    end

endmodule

// File: rtl/read_arbiter.sv
// Egress read arbiter: grants one prepared queue when egress is ready, streams that
// queue's addresses to the SRAM one per cycle and returns the words as a framed packet.
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   io_bus          read_arbiter_if master: queue addresses/pops, SRAM, egress framing
module read_arbiter
    import read_arbiter_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    read_arbiter_if.master io_bus
);

    state_e                   r_state;
    state_e                   w_state_d;
    prio_idx_t                r_sel;
    logic                     r_chan;      // 0 = channel 1, 1 = channel 2
    logic                     r_first;     // next READ cycle carries the first address
    logic                     r_drain_cnt;

    // Stage 1 tracks the address issued last cycle; stage 2 registers the SRAM word.
    logic                     r_vld1;
    logic                     r_sop1;
    logic                     r_eop1;
    logic                     r_rd_vld;
    logic                     r_rd_sop;
    logic                     r_rd_eop;
    logic [DataWidth-1:0]     r_rd_data;

    prio_idx_t                w_sel;
    logic                     w_any;
    logic                     w_grant;
    logic                     w_reading;
    logic                     w_last;
    logic                     w_rd1;
    logic                     w_rd2;
    logic [NumPriorities-1:0] w_pop;

    read_arbiter_sel u_sel (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_sp0_wrr1   (io_bus.sp0_wrr1),
        .i_grant      (w_grant),
        .i_prepared   (io_bus.prepared),
        .i_wrr_weight (io_bus.wrr_weight),
        .o_sel        (w_sel),
        .o_any        (w_any)
    );

    always_comb begin
        w_state_d = r_state;
        w_grant   = 1'b0;
        w_reading = (r_state == StRead);
        w_last    = r_chan ? io_bus.last2 : io_bus.last1;
        unique case (r_state)
            StIdle: begin
                if (io_bus.ready && w_any) begin
                    w_grant   = 1'b1;
                    w_state_d = StRead;
                end
            end
            StRead: begin
                if (w_last) w_state_d = StDrain;
            end
            StDrain: begin
                if (r_drain_cnt) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_rd1 = w_reading && !r_chan;
        w_rd2 = w_reading && r_chan;
        w_pop = NumPriorities'(1) << r_sel;

        io_bus.enb           = w_reading;
        io_bus.rd_request1   = w_rd1;
        io_bus.rd_request2   = w_rd2;
        io_bus.address_read1 = w_rd1 ? io_bus.address_to_read1 : '0;
        io_bus.address_read2 = w_rd2 ? io_bus.address_to_read2 : '0;
        io_bus.next_data     = w_rd1 ? w_pop : '0;
        io_bus.next_data2    = w_rd2 ? w_pop : '0;
        io_bus.rd_data       = r_rd_data;
        io_bus.rd_vld        = r_rd_vld;
        io_bus.rd_sop        = r_rd_sop;
        io_bus.rd_eop        = r_rd_eop;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_sel       <= '0;
            r_chan      <= 1'b0;
            r_first     <= 1'b0;
            r_drain_cnt <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            // Two DRAIN cycles: count 0 then 1.
            r_drain_cnt <= (r_state == StDrain) ? !r_drain_cnt : 1'b0;
            if (w_grant) begin
                r_sel   <= w_sel;
                r_chan  <= io_bus.sp0_wrr1;
                r_first <= 1'b1;
            end else if (w_reading) begin
                r_first <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld1    <= 1'b0;
            r_sop1    <= 1'b0;
            r_eop1    <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_rd_sop  <= 1'b0;
            r_rd_eop  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_vld1    <= w_reading;
            r_sop1    <= w_reading && r_first;
            r_eop1    <= w_reading && w_last;
            r_rd_vld  <= r_vld1;
            r_rd_sop  <= r_sop1;
            r_rd_eop  <= r_eop1;
            r_rd_data <= r_vld1 ? io_bus.data_read : '0;
        end
    end

endmodule

// File: tb/tb_read_arbiter.sv
// Directed bench for read_arbiter: a cycle table for a five-address WRR packet,
// plus hand-written SP, WRR rotation, empty-ready and mid-packet reset sequences.
module tb_read_arbiter;
    import read_arbiter_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [63:0] DBase = 64'hDA7A_0000_0000_0000;

    typedef struct {
        logic        ready;
        logic [7:0]  prepared;
        logic        last2;
        logic [11:0] addr2;
        logic [63:0] data;
        logic        enb;
        logic [7:0]  nd2;
        logic [11:0] ar2;
        logic        vld;
        logic        sop;
        logic        eop;
        logic [63:0] rdata;
    } vec_t;

    vec_t tbl [9];

    read_arbiter_if bus ();

    read_arbiter dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_enb"}, 64'(bus.enb), 64'd0);
        check({tag, "_vld"}, 64'(bus.rd_vld), 64'd0);
        check({tag, "_sop"}, 64'(bus.rd_sop), 64'd0);
        check({tag, "_eop"}, 64'(bus.rd_eop), 64'd0);
        check({tag, "_data"}, bus.rd_data, 64'd0);
        check({tag, "_nd1"}, 64'(bus.next_data), 64'd0);
        check({tag, "_nd2"}, 64'(bus.next_data2), 64'd0);
        check({tag, "_req1"}, 64'(bus.rd_request1), 64'd0);
        check({tag, "_req2"}, 64'(bus.rd_request2), 64'd0);
        check({tag, "_ar1"}, 64'(bus.address_read1), 64'd0);
        check({tag, "_ar2"}, 64'(bus.address_read2), 64'd0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called at cycle start (T); returns at the start of cycle T+len+3.
    task automatic do_packet(input int len, input logic wrr, input logic [7:0] exp_pop);
        logic [63:0] word;
        bus.ready    = 1'b1;
        bus.sp0_wrr1 = wrr;
        next_cycle();
        bus.ready = 1'b0;
        for (int k = 1; k <= len; k++) begin
            bus.last1 = !wrr && (k == len);
            bus.last2 = wrr && (k == len);
            @(negedge clk);
            check("pkt_enb", 64'(bus.enb), 64'd1);
            check("pkt_pop", 64'(wrr ? bus.next_data2 : bus.next_data), 64'(exp_pop));
            check("pkt_idle_pop", 64'(wrr ? bus.next_data : bus.next_data2), 64'd0);
            next_cycle();
        end
        bus.last1     = 1'b0;
        bus.last2     = 1'b0;
        word          = {32'hC0DE_0000, 24'h0, exp_pop};
        bus.data_read = word;
        @(negedge clk);
        check("pkt_drain_enb", 64'(bus.enb), 64'd0);
        next_cycle();
        @(negedge clk);
        check("pkt_last_vld", 64'(bus.rd_vld), 64'd1);
        check("pkt_last_eop", 64'(bus.rd_eop), 64'd1);
        check("pkt_last_sop", 64'(bus.rd_sop), 64'(len == 1));
        check("pkt_last_data", bus.rd_data, word);
        next_cycle();
    endtask

    task automatic rst_pulse();
        bus.ready = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        next_cycle();
    endtask

    initial begin
        logic [7:0] w0_exp [4];
        int         g;

        tbl[0] = '{1'b1, 8'h10, 1'b0, 12'h100, 64'h0,     1'b0, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[1] = '{1'b0, 8'h10, 1'b0, 12'h101, DBase + 1, 1'b1, 8'h10, 12'h101, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[2] = '{1'b0, 8'h10, 1'b0, 12'h102, DBase + 2, 1'b1, 8'h10, 12'h102, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[3] = '{1'b1, 8'h10, 1'b0, 12'h103, DBase + 3, 1'b1, 8'h10, 12'h103, 1'b1, 1'b1, 1'b0, DBase + 2};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 12'h104, DBase + 4, 1'b1, 8'h10, 12'h104, 1'b1, 1'b0, 1'b0, DBase + 3};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 12'h105, DBase + 5, 1'b1, 8'h10, 12'h105, 1'b1, 1'b0, 1'b0, DBase + 4};
        tbl[6] = '{1'b1, 8'hFF, 1'b0, 12'h106, DBase + 6, 1'b0, 8'h00, 12'h000, 1'b1, 1'b0, 1'b0, DBase + 5};
        tbl[7] = '{1'b1, 8'hFF, 1'b0, 12'h107, DBase + 7, 1'b0, 8'h00, 12'h000, 1'b1, 1'b0, 1'b1, DBase + 6};
        tbl[8] = '{1'b0, 8'hFF, 1'b0, 12'h108, DBase + 8, 1'b0, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 64'h0};

        w0_exp = '{8'h04, 8'h80, 8'h04, 8'h80};

        bus.sp0_wrr1         = 1'b1;
        bus.ready            = 1'b1;
        bus.prepared         = 8'hFF;
        bus.wrr_weight       = 5'd5;
        bus.data_read        = 64'h1234;
        bus.last1            = 1'b0;
        bus.last2            = 1'b0;
        bus.address_to_read1 = 12'hABC;
        bus.address_to_read2 = 12'hDEF;

        // Reset with busy-looking inputs: every output must still be 0.
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");
        bus.ready = 1'b0;
        #10 rst_n = 1'b1;

        // Five-address WRR packet on channel 2, queue 4.
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            bus.ready            = tbl[i].ready;
            bus.prepared         = tbl[i].prepared;
            bus.last2            = tbl[i].last2;
            bus.address_to_read2 = tbl[i].addr2;
            bus.data_read        = tbl[i].data;
            @(negedge clk);
            check($sformatf("row%0d_enb", i), 64'(bus.enb), 64'(tbl[i].enb));
            check($sformatf("row%0d_req2", i), 64'(bus.rd_request2), 64'(tbl[i].enb));
            check($sformatf("row%0d_req1", i), 64'(bus.rd_request1), 64'd0);
            check($sformatf("row%0d_nd2", i), 64'(bus.next_data2), 64'(tbl[i].nd2));
            check($sformatf("row%0d_nd1", i), 64'(bus.next_data), 64'd0);
            check($sformatf("row%0d_ar2", i), 64'(bus.address_read2), 64'(tbl[i].ar2));
            check($sformatf("row%0d_ar1", i), 64'(bus.address_read1), 64'd0);
            check($sformatf("row%0d_vld", i), 64'(bus.rd_vld), 64'(tbl[i].vld));
            check($sformatf("row%0d_sop", i), 64'(bus.rd_sop), 64'(tbl[i].sop));
            check($sformatf("row%0d_eop", i), 64'(bus.rd_eop), 64'(tbl[i].eop));
            check($sformatf("row%0d_data", i), bus.rd_data, tbl[i].rdata);
        end
        bus.ready = 1'b0;
        next_cycle();

        // Strict priority: back-to-back single-word packets, highest index wins.
        bus.prepared = 8'hFF;
        for (int i = 0; i < 3; i++) do_packet(1, 1'b0, 8'h80);
        bus.prepared = 8'h06;
        do_packet(3, 1'b0, 8'h04);

        // ready with nothing prepared must not start a packet.
        bus.prepared = 8'h00;
        bus.ready    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("empty_enb", 64'(bus.enb), 64'd0);
            check("empty_nd1", 64'(bus.next_data), 64'd0);
            check("empty_nd2", 64'(bus.next_data2), 64'd0);
            next_cycle();
        end
        bus.ready    = 1'b0;
        bus.prepared = 8'h06;
        do_packet(1, 1'b0, 8'h04);

        // WRR weight 5, all queues prepared, from a fresh pointer.
        rst_pulse();
        bus.prepared   = 8'hFF;
        bus.wrr_weight = 5'd5;
        for (int i = 0; i < 12; i++) begin
            g = (i < 5) ? 0 : ((i < 10) ? 1 : 2);
            do_packet(1 + (i % 3), 1'b1, 8'(1) << g);
        end

        // Reset in the middle of a long packet.
        bus.ready    = 1'b1;
        bus.sp0_wrr1 = 1'b1;
        bus.last2    = 1'b0;
        next_cycle();
        bus.ready = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("midrst_pre_enb", 64'(bus.enb), 64'd1);
        check("midrst_pre_vld", 64'(bus.rd_vld), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        @(posedge clk);
        #2 rst_n = 1'b1;
        next_cycle();
        do_packet(1, 1'b1, 8'h01);

        // Weight 0 acts as 1; pointer wraps from 7 back to 2.
        rst_pulse();
        bus.wrr_weight = 5'd0;
        bus.prepared   = 8'h84;
        for (int i = 0; i < 4; i++) do_packet(1, 1'b1, w0_exp[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
